// File: rtl/gravis_rx.sv
// Gravis GrIP pad receiver: two independent clock/data channels decoded into 14-bit button vectors (optional clock filter: GRAVIS_RX_DEGLITCH_EN).
// Latency: pad falling edge of bit 23 to dig/frame_stb is SYNC_STAGES+2 clk (+4 with the filter).
// Backpressure: none; the pad free-runs and every committed frame is presented for one cycle.
module gravis_rx #(
    parameter int TIMEOUT_CYC = 90500,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  grav_clk,
    input  logic [1:0]  grav_dat,
    output logic [13:0] dig_1,
    output logic [13:0] dig_2,
    output logic [1:0]  frame_stb,
    output logic [1:0]  frame_err,
    output logic [1:0]  link_ok
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {HUNT, DATA} state_t;

    logic [1:0][13:0] dig_w;

    assign dig_1 = dig_w[0];
    assign dig_2 = dig_w[1];

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
        logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
        logic                   clk_s, dat_s, clk_f;
        logic                   prev_q, sample;

        state_t         state_q, state_d;
        logic           seen_zero_q, seen_zero_d;
        logic [2:0]     ones_q, ones_d;
        logic [4:0]     idx_q, idx_d;
        logic [13:0]    shadow_q, shadow_d;
        logic [CW-1:0]  idle_q, idle_d;
        logic           commit_q, commit_d;
        logic [13:0]    dig_q, dig_d;
        logic           stb_q, stb_d;
        logic           err_q, err_d;
        logic           link_q, link_d;

        assign clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], grav_clk[g]};
        assign dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], grav_dat[g]};
        assign clk_s      = clk_sync_q[SYNC_STAGES-1];
        assign dat_s      = dat_sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                clk_sync_q <= '0;
                dat_sync_q <= '0;
            end else begin
                clk_sync_q <= clk_sync_d;
                dat_sync_q <= dat_sync_d;
            end
        end

`ifdef GRAVIS_RX_DEGLITCH_EN
        // Filtered level follows the synced clock only after 4 consecutive differing cycles.
        logic       filt_q, filt_d;
        logic [1:0] gcnt_q, gcnt_d;

        always_comb begin
            filt_d = filt_q;
            gcnt_d = 2'd0;
            if (clk_s != filt_q) begin
                if (gcnt_q == 2'd3) begin
                    filt_d = clk_s;
                end else begin
                    gcnt_d = gcnt_q + 2'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_q <= 1'b0;
                gcnt_q <= 2'd0;
            end else begin
                filt_q <= filt_d;
                gcnt_q <= gcnt_d;
            end
        end

        assign clk_f = filt_q;
`else
        assign clk_f = clk_s;
`endif

        assign sample = prev_q & ~clk_f;

        always_comb begin
            state_d     = state_q;
            seen_zero_d = seen_zero_q;
            ones_d      = ones_q;
            idx_d       = idx_q;
            shadow_d    = shadow_q;
            idle_d      = idle_q;
            commit_d    = 1'b0;
            dig_d       = dig_q;
            stb_d       = 1'b0;
            err_d       = 1'b0;
            link_d      = link_q;

            if (sample) begin
                idle_d = '0;
            end else if (idle_q != CW'(TIMEOUT_CYC)) begin
                idle_d = idle_q + CW'(1);
            end

            // Shadow already holds bit 23 here, so dig never sees a partial frame.
            if (commit_q) begin
                dig_d  = shadow_q;
                stb_d  = 1'b1;
                link_d = 1'b1;
            end

            if (sample) begin
                if (state_q == HUNT) begin
                    if (!dat_s) begin
                        seen_zero_d = 1'b1;
                        ones_d      = 3'd0;
                    end else if (seen_zero_q) begin
                        ones_d = ones_q + 3'd1;
                        if (ones_q == 3'd4) begin
                            state_d = DATA;
                            idx_d   = 5'd6;
                        end
                    end
                end else begin
                    idx_d = idx_q + 5'd1;
                    case (idx_q)
                        5'd6, 5'd11, 5'd16, 5'd21: begin
                            if (dat_s) begin
                                err_d       = 1'b1;
                                state_d     = HUNT;
                                seen_zero_d = 1'b0;
                                ones_d      = 3'd0;
                            end
                        end
                        5'd7:  shadow_d[9]  = dat_s;
                        5'd8:  shadow_d[8]  = dat_s;
                        5'd9:  shadow_d[12] = dat_s;
                        5'd10: shadow_d[7]  = dat_s;
                        5'd12: shadow_d[13] = dat_s;
                        5'd13: shadow_d[5]  = dat_s;
                        5'd14: shadow_d[4]  = dat_s;
                        5'd15: shadow_d[6]  = dat_s;
                        5'd17: shadow_d[11] = dat_s;
                        5'd18: shadow_d[10] = dat_s;
                        5'd19: shadow_d[3]  = dat_s;
                        5'd20: shadow_d[2]  = dat_s;
                        5'd22: shadow_d[0]  = dat_s;
                        5'd23: begin
                            shadow_d[1] = dat_s;
                            commit_d    = 1'b1;
                            state_d     = HUNT;
                            seen_zero_d = 1'b0;
                            ones_d      = 3'd0;
                        end
                        default: ;
                    endcase
                end
            end else if (idle_q == CW'(TIMEOUT_CYC - 1)) begin
                link_d      = 1'b0;
                dig_d       = '0;
                state_d     = HUNT;
                seen_zero_d = 1'b0;
                ones_d      = 3'd0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q      <= 1'b0;
                state_q     <= HUNT;
                seen_zero_q <= 1'b0;
                ones_q      <= 3'd0;
                idx_q       <= 5'd0;
                shadow_q    <= '0;
                idle_q      <= '0;
                commit_q    <= 1'b0;
                dig_q       <= '0;
                stb_q       <= 1'b0;
                err_q       <= 1'b0;
                link_q      <= 1'b0;
            end else begin
                prev_q      <= clk_f;
                state_q     <= state_d;
                seen_zero_q <= seen_zero_d;
                ones_q      <= ones_d;
                idx_q       <= idx_d;
                shadow_q    <= shadow_d;
                idle_q      <= idle_d;
                commit_q    <= commit_d;
                dig_q       <= dig_d;
                stb_q       <= stb_d;
                err_q       <= err_d;
                link_q      <= link_d;
            end
        end

        assign dig_w[g]     = dig_q;
        assign frame_stb[g] = stb_q;
        assign frame_err[g] = err_q;
        assign link_ok[g]   = link_q;
    end

endmodule

// File: tb/tb_gravis_rx.sv
// Bench for gravis_rx: drives GrIP frames on both channels, expected vectors queued per channel and checked on frame_stb.
module tb_gravis_rx;

    localparam int T  = 200;
    localparam int SS = 2;
`ifdef GRAVIS_RX_DEGLITCH_EN
    localparam int LAT = SS + 6;
`else
    localparam int LAT = SS + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  grav_clk;
    logic [1:0]  grav_dat;
    logic [13:0] dig_1, dig_2;
    logic [1:0]  frame_stb, frame_err, link_ok;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fall_cyc[2];
    int stb_cyc[2];
    int stb_cnt[2];
    int err_seen[2];
    bit glitch = 1'b0;
    logic [13:0] exp_q0[$];
    logic [13:0] exp_q1[$];
    logic [13:0] mon_exp;

    gravis_rx #(.TIMEOUT_CYC(T), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .grav_clk  (grav_clk),
        .grav_dat  (grav_dat),
        .dig_1     (dig_1),
        .dig_2     (dig_2),
        .frame_stb (frame_stb),
        .frame_err (frame_err),
        .link_ok   (link_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (frame_err[c] === 1'b1) err_seen[c]++;
            if (frame_stb[c] === 1'b1) begin
                stb_cnt[c]++;
                stb_cyc[c] = cyc;
                if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
                    check("stb_unexpected", 32'd1, 32'd0);
                end else begin
                    if (c == 0) mon_exp = exp_q0.pop_front();
                    else        mon_exp = exp_q1.pop_front();
                    check((c == 0) ? "dig_1_commit" : "dig_2_commit", (c == 0) ? dig_1 : dig_2, mon_exp);
                    check("link_ok_at_stb", link_ok[c], 1);
                    check("commit_latency", cyc - fall_cyc[c], LAT);
                end
            end
        end
    end

    function automatic logic [23:0] mk_frame(input logic [13:0] btn);
        logic [23:0] f;
        f = '0;
        f[5:1] = 5'b11111;
        f[22] = btn[0];  f[23] = btn[1];  f[20] = btn[2];  f[19] = btn[3];
        f[14] = btn[4];  f[13] = btn[5];  f[15] = btn[6];  f[10] = btn[7];
        f[8]  = btn[8];  f[7]  = btn[9];  f[18] = btn[10]; f[17] = btn[11];
        f[9]  = btn[12]; f[12] = btn[13];
        return f;
    endfunction

    task automatic send_bit(input int ch, input bit b);
        @(negedge clk);
        grav_dat[ch] = b;
        repeat (6) @(negedge clk);
        if (glitch) begin
            grav_clk[ch] = 1'b0;
            repeat (2) @(negedge clk);
            grav_clk[ch] = 1'b1;
            repeat (6) @(negedge clk);
        end
        grav_clk[ch] = 1'b0;
        fall_cyc[ch] = cyc;
        repeat (6) @(negedge clk);
        grav_clk[ch] = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input int ch, input logic [23:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(ch, f[i]);
    endtask

    task automatic good_frame(input int ch, input logic [13:0] btn);
        if (ch == 0) exp_q0.push_back(btn);
        else         exp_q1.push_back(btn);
        send_bits(ch, mk_frame(btn), 0, 23);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] f;
        int e0, e1, waited;
        for (int c = 0; c < 2; c++) begin
            fall_cyc[c] = 0; stb_cyc[c] = 0; stb_cnt[c] = 0; err_seen[c] = 0;
        end
        grav_clk = 2'b11;
        grav_dat = 2'b00;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dig_1", dig_1, 0);
        check("rst_dig_2", dig_2, 0);
        check("rst_stb", frame_stb, 0);
        check("rst_err", frame_err, 0);
        check("rst_link", link_ok, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Sel + Left on P1, twice back to back
        good_frame(0, 14'h0202);
        good_frame(0, 14'h0202);
        check("p1_dig", dig_1, 14'h0202);
        check("p1_link", link_ok[0], 1);
        check("p1_stb_count", stb_cnt[0], 2);
        check("p1_dig_2_idle", dig_2, 0);

        // Reset in the middle of a frame, then a stray frame tail
        send_bits(0, mk_frame(14'h3FFF), 0, 12);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dig_1", dig_1, 0);
        check("midrst_link", link_ok, 0);
        rst_n = 1'b1;
        send_bits(0, mk_frame(14'h3FFF), 12, 23);
        check("tail_no_commit", stb_cnt[0], 2);
        check("tail_no_err", err_seen[0], 0);
        good_frame(0, 14'h1555);
        check("after_tail_dig", dig_1, 14'h1555);

        // Six-ones header aborts on the first separator
        e0 = err_seen[0];
        f = 24'h00007E;
        send_bits(0, f, 0, 6);
        check("six_ones_err", err_seen[0], e0 + 1);
        check("six_ones_hold", dig_1, 14'h1555);
        good_frame(0, 14'h2AAA);
        check("six_ones_recover", dig_1, 14'h2AAA);

        // P2: all pressed, all released, pattern, broken separator, recovery
        good_frame(1, 14'h3FFF);
        check("p2_all", dig_2, 14'h3FFF);
        good_frame(1, 14'h0000);
        check("p2_none", dig_2, 0);
        good_frame(1, 14'h1234);
        e1 = err_seen[1];
        f = mk_frame(14'h3FFF);
        f[16] = 1'b1;
        send_bits(1, f, 0, 23);
        check("sep16_err", err_seen[1], e1 + 1);
        check("sep16_hold", dig_2, 14'h1234);
        good_frame(1, 14'h0ABC);
        check("sep16_recover", dig_2, 14'h0ABC);
        check("p2_err_only_p2", err_seen[0], e0 + 1);

        // Link loss with B1 held, then recovery
        good_frame(0, 14'h0010);
        check("to_b1_held", dig_1[4], 1);
        waited = 0;
        while (link_ok[0] !== 1'b0 && waited < 2 * T) begin
            @(negedge clk);
            waited++;
        end
        check("to_link_dropped", link_ok[0], 0);
        check("to_cycles", cyc - stb_cyc[0], T - 1);
        check("to_dig_cleared", dig_1, 0);
        check("to_no_err", err_seen[0], e0 + 1);
        good_frame(0, 14'h0010);
        check("to_resume_dig", dig_1, 14'h0010);
        check("to_resume_link", link_ok[0], 1);

`ifdef GRAVIS_RX_DEGLITCH_EN
        // Short low glitch inside every bit must not be taken as a sample
        glitch = 1'b1;
        good_frame(0, 14'h0C03);
        glitch = 1'b0;
        check("glitch_dig", dig_1, 14'h0C03);
        check("glitch_no_err", err_seen[0], e0 + 1);
`endif

        repeat (10) @(negedge clk);
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
